// File: rtl/inject_pkg.sv
// Shared definitions for the local-injection scheduler.
// Holds the address field widths, link bit positions in link_busy/inj_slot,
// the one-hot route encodings presented on inj_dir, and the FSM state type.
package inject_pkg;

  localparam int ROW_W = 3;
  localparam int COL_W = 3;
  localparam int AD_W  = ROW_W + COL_W;

  // Bit positions within link_busy / inj_slot
  localparam int LINK_E = 0;
  localparam int LINK_W = 1;
  localparam int LINK_N = 2;
  localparam int LINK_S = 3;

  // One-hot route encodings for inj_dir
  localparam logic [4:0] DIR_EAST  = 5'b00001;
  localparam logic [4:0] DIR_WEST  = 5'b00010;
  localparam logic [4:0] DIR_NORTH = 5'b00100;
  localparam logic [4:0] DIR_SOUTH = 5'b01000;
  localparam logic [4:0] DIR_LOCAL = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_STARVED = 2'd2
  } state_t;

endpackage

// File: rtl/inject_scheduler_if.sv
// Bundle of node-side and router-side signals of the injection scheduler.
//   master : node/router side (drives local_valid, local_ad, link_busy)
//   slave  : the scheduler (drives local_ready and all inj_* outputs,
//            starve and occupancy)
interface inject_scheduler_if #(
  parameter int DEPTH = 4
);
  import inject_pkg::*;

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              local_valid;
  logic [AD_W-1:0]   local_ad;
  logic              local_ready;
  logic [3:0]        link_busy;
  logic              inj_valid;
  logic [3:0]        inj_slot;
  logic [AD_W-1:0]   inj_ad;
  logic [4:0]        inj_dir;
  logic              starve;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output local_valid, local_ad, link_busy,
    input  local_ready, inj_valid, inj_slot, inj_ad, inj_dir, starve, occupancy
  );

  modport slave (
    input  local_valid, local_ad, link_busy,
    output local_ready, inj_valid, inj_slot, inj_ad, inj_dir, starve, occupancy
  );

endinterface

// File: rtl/inject_fifo.sv
// DEPTH x WIDTH synchronous FIFO holding locally offered flit addresses.
// Head entry is read combinationally so the scheduler can route it in the
// same cycle it decides to pop.
//   clk, rst : clock, asynchronous active-high reset
//   push/wdata : write at tail (ignored when full)
//   pop/rdata  : head data, advance head (ignored when empty)
//   full, empty, count : fill status (count is registered)
module inject_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inject_scheduler.sv
// Local-injection controller for a bufferless mesh router.
// Queues flits from the local node and each cycle issues the head flit on
// the first free link (north, south, east, west), or ejects it locally if it
// is addressed to this router. Flags starvation when blocked too long.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : inject_scheduler_if slave modport (node handshake, link
//              occupancy in, registered issue/starve/occupancy out)
module inject_scheduler
  import inject_pkg::*;
#(
  parameter int              DEPTH        = 4,
  parameter int              STARVE_LIMIT = 15,
  parameter logic [ROW_W-1:0] ROUTER_ROW  = 3'd4,
  parameter logic [COL_W-1:0] ROUTER_COL  = 3'd4
) (
  input  logic               clk,
  input  logic               rst,
  inject_scheduler_if.slave  bus
);

  localparam int         OCC_W = $clog2(DEPTH) + 1;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic              full, empty, push, pop, eject;
  logic [AD_W-1:0]   head_ad;
  logic [OCC_W-1:0]  count;
  logic [ROW_W-1:0]  head_row;
  logic [COL_W-1:0]  head_col;
  logic [4:0]        head_dir;
  logic [3:0]        free_slot;

  state_t            state_q, state_d;
  logic [7:0]        blk_cnt_q, blk_cnt_d;
  logic              inj_valid_q, starve_q;
  logic [3:0]        inj_slot_q;
  logic [AD_W-1:0]   inj_ad_q;
  logic [4:0]        inj_dir_q;

  assign bus.local_ready = !rst && !full;
  assign push            = bus.local_valid && bus.local_ready;

  inject_fifo #(.DEPTH(DEPTH), .WIDTH(AD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (bus.local_ad),
    .pop   (pop),
    .rdata (head_ad),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head_row = head_ad[AD_W-1:COL_W];
  assign head_col = head_ad[COL_W-1:0];

  // Productive direction of the head flit: column first, then row.
  always_comb begin
    head_dir = DIR_LOCAL;
    if (head_col > ROUTER_COL)      head_dir = DIR_EAST;
    else if (head_col < ROUTER_COL) head_dir = DIR_WEST;
    else if (head_row > ROUTER_ROW) head_dir = DIR_NORTH;
    else if (head_row < ROUTER_ROW) head_dir = DIR_SOUTH;
  end

  assign eject = (head_dir == DIR_LOCAL);

  // Fixed-priority free-link grant; slot need not match head_dir.
  always_comb begin
    free_slot = 4'b0000;
    if (!bus.link_busy[LINK_N])      free_slot[LINK_N] = 1'b1;
    else if (!bus.link_busy[LINK_S]) free_slot[LINK_S] = 1'b1;
    else if (!bus.link_busy[LINK_E]) free_slot[LINK_E] = 1'b1;
    else if (!bus.link_busy[LINK_W]) free_slot[LINK_W] = 1'b1;
  end

  assign pop = !empty && (eject || (free_slot != 4'b0000));

  // Next-state and blocked-cycle counter
  always_comb begin
    state_d   = state_q;
    blk_cnt_d = blk_cnt_q;
    case (state_q)
      ST_IDLE: begin
        blk_cnt_d = '0;
        if (push) state_d = ST_WAIT;
      end
      ST_WAIT, ST_STARVED: begin
        if (pop) begin
          blk_cnt_d = '0;
          // A concurrent push keeps the queue non-empty.
          state_d = (count == OCC_W'(1) && !push) ? ST_IDLE : ST_WAIT;
        end else if (state_q == ST_WAIT) begin
          if (blk_cnt_q < LIMIT) blk_cnt_d = blk_cnt_q + 8'd1;
          if (blk_cnt_d == LIMIT) state_d = ST_STARVED;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        blk_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      blk_cnt_q   <= '0;
      inj_valid_q <= 1'b0;
      inj_slot_q  <= '0;
      inj_ad_q    <= '0;
      inj_dir_q   <= '0;
      starve_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_cnt_q   <= blk_cnt_d;
      inj_valid_q <= pop;
      inj_slot_q  <= (pop && !eject) ? free_slot : 4'b0000;
      inj_ad_q    <= pop ? head_ad : '0;
      inj_dir_q   <= pop ? head_dir : 5'b00000;
      starve_q    <= (state_d == ST_STARVED);
    end
  end

  assign bus.inj_valid = inj_valid_q;
  assign bus.inj_slot  = inj_slot_q;
  assign bus.inj_ad    = inj_ad_q;
  assign bus.inj_dir   = inj_dir_q;
  assign bus.starve    = starve_q;
  assign bus.occupancy = count;

endmodule

// File: tb/tb_inject_scheduler.sv
// Self-checking bench for inject_scheduler: stimulus queues expected issues,
// a negedge monitor pops and compares whenever inj_valid is high.
module tb_inject_scheduler;
  import inject_pkg::*;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inject_scheduler_if #(.DEPTH(4)) bus ();

  inject_scheduler #(
    .DEPTH(4), .STARVE_LIMIT(15), .ROUTER_ROW(3'd4), .ROUTER_COL(3'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [5:0] ad;
    logic [3:0] slot;
    logic [4:0] dir;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.inj_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got ad=%0h slot=%0h dir=%0h, expected no issue",
                 bus.inj_ad, bus.inj_slot, bus.inj_dir);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue.ad",   32'(bus.inj_ad),   32'(e.ad));
        check("issue.slot", 32'(bus.inj_slot), 32'(e.slot));
        check("issue.dir",  32'(bus.inj_dir),  32'(e.dir));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] ad, input logic [3:0] busy,
                      input logic [3:0] slot, input logic [4:0] dir);
    exp_t e;
    bus.local_valid = 1'b1;
    bus.local_ad    = ad;
    bus.link_busy   = busy;
    e.ad = ad; e.slot = slot; e.dir = dir;
    exp_q.push_back(e);
    step();
    bus.local_valid = 1'b0;
  endtask

  // Streaming vectors with hand-computed routes (router at 4,4, no links busy)
  logic [5:0] s_ad   [8] = '{6'b000_000, 6'b111_111, 6'b001_100, 6'b111_100,
                             6'b100_100, 6'b011_101, 6'b100_011, 6'b000_100};
  logic [3:0] s_slot [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
                             4'b0000, 4'b0100, 4'b0100, 4'b0100};
  logic [4:0] s_dir  [8] = '{5'b00010, 5'b00001, 5'b01000, 5'b00100,
                             5'b10000, 5'b00001, 5'b00010, 5'b01000};

  initial begin
    rst             = 1'b1;
    bus.local_valid = 1'b0;
    bus.local_ad    = '0;
    bus.link_busy   = 4'b0000;
    step();
    step();
    check("reset.inj_valid",   32'(bus.inj_valid),   0);
    check("reset.inj_slot",    32'(bus.inj_slot),    0);
    check("reset.inj_ad",      32'(bus.inj_ad),      0);
    check("reset.inj_dir",     32'(bus.inj_dir),     0);
    check("reset.starve",      32'(bus.starve),      0);
    check("reset.occupancy",   32'(bus.occupancy),   0);
    check("reset.local_ready", 32'(bus.local_ready), 0);
    rst = 1'b0;
    #1;
    check("release.local_ready", 32'(bus.local_ready), 1);

    // Basic east route on north slot
    push(6'b101_110, 4'b0000, 4'b0100, 5'b00001);
    check("basic.occupancy_after_push", 32'(bus.occupancy), 1);
    step();
    check("basic.occupancy_after_issue", 32'(bus.occupancy), 0);

    // North busy -> south slot
    push(6'b110_100, 4'b0100, 4'b1000, 5'b00100);
    step();

    // Self-ejection with all links busy
    push(6'b100_100, 4'b1111, 4'b0000, 5'b10000);
    step();
    step();

    // Fill with all links busy, then starvation
    push(6'b010_001, 4'b1111, 4'b0001, 5'b00010);
    push(6'b110_110, 4'b1111, 4'b0001, 5'b00001);
    push(6'b000_100, 4'b1111, 4'b0001, 5'b01000);
    push(6'b111_100, 4'b1111, 4'b0001, 5'b00100);
    check("full.local_ready", 32'(bus.local_ready), 0);
    check("full.occupancy",   32'(bus.occupancy),   4);
    bus.local_valid = 1'b1;
    bus.local_ad    = 6'b111_111;
    step();
    bus.local_valid = 1'b0;
    check("full.push_refused", 32'(bus.occupancy), 4);
    for (int i = 0; i < 10; i++) step();
    check("starve.before_limit", 32'(bus.starve), 0);
    step();
    check("starve.at_limit", 32'(bus.starve), 1);
    bus.link_busy = 4'b1110;
    step();
    check("starve.clear_on_pop", 32'(bus.starve),    0);
    check("starve.occ_after_pop", 32'(bus.occupancy), 3);
    step();
    step();
    step();
    check("drain.occupancy", 32'(bus.occupancy), 0);

    // Back-to-back streaming with wrap-around
    bus.link_busy = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      push(s_ad[i], 4'b0000, s_slot[i], s_dir[i]);
      check("stream.occupancy", 32'(bus.occupancy), 1);
    end
    step();
    step();
    check("stream.drained", 32'(bus.occupancy), 0);

    // Reset while 3 flits queued and starving
    push(6'b000_001, 4'b1111, 4'b0100, 5'b00010);
    push(6'b000_010, 4'b1111, 4'b0100, 5'b00010);
    push(6'b000_011, 4'b1111, 4'b0100, 5'b00010);
    for (int i = 0; i < 40; i++) begin
      if (bus.starve === 1'b1) break;
      step();
    end
    check("rstmid.starve_before", 32'(bus.starve),    1);
    check("rstmid.occ_before",    32'(bus.occupancy), 3);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rstmid.starve",      32'(bus.starve),      0);
    check("rstmid.occupancy",   32'(bus.occupancy),   0);
    check("rstmid.local_ready", 32'(bus.local_ready), 0);
    check("rstmid.inj_valid",   32'(bus.inj_valid),   0);
    bus.link_busy = 4'b0000;
    step();
    rst = 1'b0;
    step();
    check("rstmid.occ_after_release", 32'(bus.occupancy), 0);
    for (int i = 0; i < 4; i++) step();

    // Asynchronous drop of an active inj_valid
    push(6'b101_101, 4'b0000, 4'b0100, 5'b00001);
    step();
    check("rstasync.valid_before", 32'(bus.inj_valid), 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rstasync.valid_drop", 32'(bus.inj_valid), 0);
    check("rstasync.ad_drop",    32'(bus.inj_ad),    0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();

    check("scoreboard.empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inject_scheduler.md
# inject_scheduler

Local-injection controller for the bufferless mesh router. It queues flits offered by the local node and, each cycle, grants the head flit one free outgoing link slot using fixed priority north, south, east, west. It computes the head flit's one-hot productive direction and raises a starvation flag when injection is blocked too long. It sits between the node interface and the router's per-link address/direction registers, replacing ad-hoc per-link injection.

## Interface
- DEPTH, 4, local queue entries (power of two, ≥2)
- STARVE_LIMIT, 15, consecutive blocked cycles before `starve` asserts (1..255)
- ROUTER_ROW, 3'd4, this router's row coordinate
- ROUTER_COL, 3'd4, this router's column coordinate

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- local_valid  in  1  local node offers a flit
- local_ad  in  6  destination address; [5:3] row, [2:0] column
- local_ready  out  1  queue can accept; `!rst && !full` (combinational)
- link_busy  in  4  per-link occupancy this cycle; bit0 east, 1 west, 2 north, 3 south
- inj_valid  out  1  registered; injection/ejection issued this cycle
- inj_slot  out  4  registered one-hot link granted (same bit order as link_busy); 0 for self-ejection
- inj_ad  out  6  registered address of issued flit
- inj_dir  out  5  registered one-hot route: 00001 east, 00010 west, 00100 north, 01000 south, 10000 local
- starve  out  1  registered starvation flag
- occupancy  out  log2(DEPTH)+1  registered queue fill level

## Operation
- Push: `local_valid && local_ready` at a rising edge writes `local_ad` at the tail. No push when full, even if a pop occurs the same cycle.
- Head selection, evaluated combinationally each cycle when the queue is non-empty.
  - Head destination equals (ROUTER_ROW, ROUTER_COL): eject. Pop, inj_dir=10000, inj_slot=0. No free link is needed.
  - Otherwise, grant the first free link in order north(bit2), south(bit3), east(bit0), west(bit1). Pop the head, set inj_slot to that bit, and set inj_dir from the head address.
  - Otherwise (all four links busy): no pop; inj_valid=0.
- Direction:
  - col>ROUTER_COL: east; col<ROUTER_COL: west.
  - col equal: row>ROUTER_ROW north, row<ROUTER_ROW south, equal local.
  - Unsigned 3-bit compares.
- The granted slot need not match inj_dir. Deflection is the router's job.
- At most one flit is issued per cycle.
- FSM states:
  - IDLE: queue empty.
  - WAIT: queue non-empty, blocked count < STARVE_LIMIT.
  - STARVED: blocked count == STARVE_LIMIT; `starve`=1.
- FSM transitions:
  - IDLE→WAIT on push.
  - WAIT/STARVED→IDLE on a pop that empties the queue.
  - WAIT→STARVED when the counter reaches the limit.
  - STARVED→WAIT on any pop that leaves the queue non-empty.
- Blocked counter (8-bit): increments in WAIT on a blocked cycle, saturates at STARVE_LIMIT, and clears on any pop.

## Timing
- Reset values (asynchronous, held while rst=1):
  - Queue empty, pointers 0, counter 0, state IDLE.
  - inj_valid=0, inj_slot=0, inj_ad=0, inj_dir=0, starve=0, occupancy=0.
  - local_ready=0 during reset.
- Latency: a flit pushed at edge k into an empty queue is issued at edge k+1. It is visible on inj_* during cycle k+1..k+2, provided a link is free in cycle k..k+1. No same-cycle push-to-issue bypass.
- link_busy is sampled in the same cycle as the pop decision.
- Simultaneous push and pop: allowed when not full; occupancy unchanged.
- Pointer wrap-around modulo DEPTH.
- Reset mid-operation discards all queued flits. inj_valid drops immediately (asynchronous).
- starve asserts at the edge where the counter reaches STARVE_LIMIT. It deasserts at the edge of the next pop.

## Structure
- Shared package `inject_pkg`:
  - Direction constants DIR_EAST/WEST/NORTH/SOUTH/LOCAL.
  - Link index constants LINK_E=0, W=1, N=2, S=3.
  - Address field widths ROW_W=3, COL_W=3.
  - FSM state typedef.
- One sub-module, `inject_fifo`:
  - Parameterised DEPTH x 6 synchronous FIFO with async reset.
  - Ports: full, empty, count.
- Priority grant, direction compute and FSM live in the top.

## Test plan
- Reset then push 6'b101_110 with link_busy=4'b0000 → one cycle later inj_valid=1, inj_slot=4'b0100, inj_dir=5'b00001, inj_ad=6'b101_110.
- Push 6'b110_100 with link_busy=4'b0100 → inj_slot=4'b1000, inj_dir=5'b00100.
- Push 6'b100_100 with link_busy=4'b1111 → issued next cycle with inj_slot=0, inj_dir=5'b10000.
- Fill with 4 flits, link_busy=4'b1111:
  - local_ready=0, occupancy=4.
  - After 15 blocked cycles starve=1.
  - Free east (4'b1110) → inj_slot=4'b0001 and starve=0 on the following edge.
- Push every cycle with link_busy=0 → steady one issue per cycle, occupancy stays 1, pointers wrap without loss or reordering.
- Assert rst while 3 flits are queued and starve=1 → all outputs 0 immediately, occupancy=0 after release, and no stale flit is issued.
